// File: rtl/i2c_regmap.sv
// i2c_regmap: pointer-based register file behind i2c_slave; resynchronises its strobes into clk.
// Optional macro I2C_REGMAP_PTR_WRAP_EN: pointer wraps modulo NUM_REGS instead of saturating.
module i2c_regmap #(
   parameter int         NUM_REGS = 8,
   parameter logic [7:0] REG_RST  = 8'h00
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i2c_start,
   input  logic                            i2c_stop,
   input  logic                            i2c_data_vld,
   input  logic                            i2c_r_w,
   input  logic [7:0]                      i2c_data_out,
   output logic [7:0]                      i2c_data_in,
   output logic                            i2c_ready,
   output logic                            reg_wr_en,
   output logic [$clog2(NUM_REGS)-1:0]     reg_wr_addr,
   output logic [7:0]                      reg_wr_data,
   output logic [NUM_REGS*8-1:0]           regs_flat
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

   state_t              state_q, state_d;
   logic [2:0]          start_sync_q, stop_sync_q, vld_sync_q;
   logic [1:0]          rw_sync_q;
   logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_inc;
   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          data_in_q;
   logic                ready_q, ready_d;
   logic [1:0]          busy_q, busy_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                start_ev, stop_ev, byte_ev;

   // Two flops resynchronise each strobe; the third holds the previous value for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_sync_q <= '0;
         stop_sync_q  <= '0;
         vld_sync_q   <= '0;
         rw_sync_q    <= '0;
      end else begin
         start_sync_q <= {start_sync_q[1:0], i2c_start};
         stop_sync_q  <= {stop_sync_q[1:0], i2c_stop};
         vld_sync_q   <= {vld_sync_q[1:0], i2c_data_vld};
         rw_sync_q    <= {rw_sync_q[0], i2c_r_w};
      end
   end

   assign start_ev = start_sync_q[1] & ~start_sync_q[2];
   assign stop_ev  = stop_sync_q[1] & ~stop_sync_q[2];
   assign byte_ev  = ~vld_sync_q[1] & vld_sync_q[2];

`ifdef I2C_REGMAP_PTR_WRAP_EN
   assign ptr_inc = ptr_q + 1'b1;
`else
   assign ptr_inc = (&ptr_q) ? ptr_q : ptr_q + 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ready_d   = 1'b1;
      busy_d    = 2'd0;
      // The byte is handled in the state it arrived in; start/stop then override the next state.
      if (byte_ev) begin
         case (state_q)
            ADDR: begin
               if (rw_sync_q[1]) begin
                  ptr_d   = ptr_inc;
                  state_d = READ;
               end else begin
                  ptr_d   = i2c_data_out[ADDR_W-1:0];
                  state_d = WRITE;
               end
            end
            WRITE: begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = i2c_data_out;
               ptr_d     = ptr_inc;
            end
            READ:    ptr_d = ptr_inc;
            default: ;
         endcase
      end
      if (stop_ev) begin
         state_d = IDLE;
      end else if (start_ev) begin
         state_d = ADDR;
      end
      // ready drops for two cycles so data_in has settled on the new pointer before it returns.
      if (byte_ev) begin
         ready_d = 1'b0;
         busy_d  = 2'd2;
      end else if (busy_q != 2'd0) begin
         busy_d  = busy_q - 1'b1;
         ready_d = (busy_q == 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         data_in_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 2'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= REG_RST;
         end
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         data_in_q <= regs_q[ptr_q];
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         if (wr_en_d) begin
            regs_q[ptr_q] <= i2c_data_out;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = regs_q[g];
   end

   assign i2c_data_in = data_in_q;
   assign i2c_ready   = ready_q;
   assign reg_wr_en   = wr_en_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_regmap.sv
// Self-checking bench for i2c_regmap: vector table, timing sequences and randomized ops vs a model.
module tb_i2c_regmap;
   localparam int         N    = 8;
   localparam int         AW   = $clog2(N);
   localparam logic [7:0] RRST = 8'h00;

   localparam int K_START = 0, K_STOP = 1, K_BYTE = 2;
   localparam int M_IDLE = 0, M_ADDR = 1, M_WRITE = 2, M_READ = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i2c_start = 1'b0, i2c_stop = 1'b0, i2c_data_vld = 1'b0, i2c_r_w = 1'b0;
   logic [7:0]    i2c_data_out = 8'h00;
   logic [7:0]    i2c_data_in;
   logic          i2c_ready;
   logic          reg_wr_en;
   logic [AW-1:0] reg_wr_addr;
   logic [7:0]    reg_wr_data;
   logic [N*8-1:0] regs_flat;

   i2c_regmap #(.NUM_REGS(N), .REG_RST(RRST)) dut (
      .clk(clk), .rst(rst),
      .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_data_vld(i2c_data_vld),
      .i2c_r_w(i2c_r_w), .i2c_data_out(i2c_data_out),
      .i2c_data_in(i2c_data_in), .i2c_ready(i2c_ready),
      .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .regs_flat(regs_flat)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: plain integers following the pointer protocol rules.
   int m_state = M_IDLE;
   int m_ptr   = 0;
   int m_regs [N];
   int exp_wr, exp_addr, exp_data;

   // Write-strobe monitor.
   int wr_seen = 0;
   int wr_addr_seen = 0, wr_data_seen = 0;
   always @(negedge clk) begin
      if (reg_wr_en === 1'b1) begin
         wr_seen      = wr_seen + 1;
         wr_addr_seen = int'(reg_wr_addr);
         wr_data_seen = int'(reg_wr_data);
      end
   end

   typedef struct {
      int         kind;
      logic       rw;
      logic [7:0] d;
      int         e_wr;
      int         e_addr;
      int         e_din;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic int m_inc(input int p);
`ifdef I2C_REGMAP_PTR_WRAP_EN
      return (p + 1) % N;
`else
      return (p == N - 1) ? p : p + 1;
`endif
   endfunction

   task automatic m_reset();
      m_state = M_IDLE;
      m_ptr   = 0;
      for (int k = 0; k < N; k++) m_regs[k] = int'(RRST);
   endtask

   task automatic m_byte(input logic rw, input logic [7:0] d);
      exp_wr = 0;
      case (m_state)
         M_ADDR: begin
            if (rw) begin
               m_ptr = m_inc(m_ptr);
               m_state = M_READ;
            end else begin
               m_ptr = int'(d) % N;
               m_state = M_WRITE;
            end
         end
         M_WRITE: begin
            exp_wr = 1; exp_addr = m_ptr; exp_data = int'(d);
            m_regs[m_ptr] = int'(d);
            m_ptr = m_inc(m_ptr);
         end
         M_READ: m_ptr = m_inc(m_ptr);
         default: ;
      endcase
   endtask

   function automatic logic [7:0] dut_reg(input int k);
      return regs_flat[8*k +: 8];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      wr_seen = 0; exp_wr = 0;
      i2c_start = 1'b1; tick(4);
      i2c_start = 1'b0; tick(6);
      m_state = M_ADDR;
   endtask

   task automatic do_stop();
      wr_seen = 0; exp_wr = 0;
      i2c_stop = 1'b1; tick(4);
      i2c_stop = 1'b0; tick(6);
      m_state = M_IDLE;
   endtask

   task automatic send_byte(input logic rw, input logic [7:0] d);
      wr_seen = 0;
      i2c_r_w = rw; i2c_data_out = d;
      i2c_data_vld = 1'b1; tick(4);
      i2c_data_vld = 1'b0; tick(8);
      m_byte(rw, d);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".wr_cnt"}, wr_seen, exp_wr);
      if (exp_wr != 0) begin
         chk({tag, ".wr_addr"}, wr_addr_seen, exp_addr);
         chk({tag, ".wr_data"}, wr_data_seen, exp_data);
      end
      chk({tag, ".data_in"}, {24'h0, i2c_data_in}, m_regs[m_ptr]);
      chk({tag, ".ready"}, {31'h0, i2c_ready}, 1);
      for (int k = 0; k < N; k++) chk({tag, ".reg"}, {24'h0, dut_reg(k)}, m_regs[k]);
   endtask

   // Drives one byte and records per-cycle ready/wr_en/data_in after the data_vld fall.
   logic rdy_h [12];
   logic wen_h [12];
   logic [7:0] din_h [12];
   task automatic measure_byte(input logic rw, input logic [7:0] d);
      wr_seen = 0;
      i2c_r_w = rw; i2c_data_out = d;
      i2c_data_vld = 1'b1; tick(4);
      i2c_data_vld = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         rdy_h[k] = i2c_ready; wen_h[k] = reg_wr_en; din_h[k] = i2c_data_in;
      end
      m_byte(rw, d);
   endtask

   task automatic analyse(input string tag, output int first_low);
      int lows, wens, first_wen;
      lows = 0; wens = 0; first_low = -1; first_wen = -1;
      for (int k = 0; k < 12; k++) begin
         if (rdy_h[k] !== 1'b1) begin lows++; if (first_low < 0) first_low = k; end
         if (wen_h[k] === 1'b1) begin wens++; if (first_wen < 0) first_wen = k; end
      end
      chk({tag, ".ready_low_cycles"}, lows, 2);
      chk({tag, ".wr_en_cycles"}, wens, exp_wr);
      if (exp_wr != 0) chk({tag, ".wr_with_ready_drop"}, first_wen, first_low);
      if (first_low < 0) first_low = 0;
   endtask

   initial begin
      int fl;
      int r;
      m_reset();
      exp_wr = 0;

      // Reset state while rst is held.
      tick(3);
      chk("rst.data_in", {24'h0, i2c_data_in}, 0);
      chk("rst.ready", {31'h0, i2c_ready}, 0);
      chk("rst.wr_en", {31'h0, reg_wr_en}, 0);
      chk("rst.wr_addr", {{(32-AW){1'b0}}, reg_wr_addr}, 0);
      chk("rst.wr_data", {24'h0, reg_wr_data}, 0);
      chk("rst.regs_lo", regs_flat[31:0], {4{RRST}});
      chk("rst.regs_hi", regs_flat[63:32], {4{RRST}});
      rst = 1'b0;
      tick(1);
      chk("rst.ready_after_release", {31'h0, i2c_ready}, 1);
      tick(3);

      // Pointer write, two data writes, then pointer + repeated start + two reads.
      vecs[0]  = '{K_START, 1'b0, 8'h00, 0, 0, 8'h00};
      vecs[1]  = '{K_BYTE,  1'b0, 8'h02, 0, 0, 8'h00};
      vecs[2]  = '{K_BYTE,  1'b0, 8'hA5, 1, 2, 8'h00};
      vecs[3]  = '{K_BYTE,  1'b0, 8'h5A, 1, 3, 8'h00};
      vecs[4]  = '{K_STOP,  1'b0, 8'h00, 0, 0, 8'h00};
      vecs[5]  = '{K_START, 1'b0, 8'h00, 0, 0, 8'h00};
      vecs[6]  = '{K_BYTE,  1'b0, 8'h02, 0, 0, 8'hA5};
      vecs[7]  = '{K_START, 1'b0, 8'h00, 0, 0, 8'hA5};
      vecs[8]  = '{K_BYTE,  1'b1, 8'h00, 0, 0, 8'h5A};
      vecs[9]  = '{K_BYTE,  1'b1, 8'h00, 0, 0, 8'h00};
      vecs[10] = '{K_STOP,  1'b0, 8'h00, 0, 0, 8'h00};
      for (int i = 0; i < 11; i++) begin
         case (vecs[i].kind)
            K_START: do_start();
            K_STOP:  do_stop();
            default: send_byte(vecs[i].rw, vecs[i].d);
         endcase
         chk($sformatf("vec%0d.wr_cnt", i), wr_seen, vecs[i].e_wr);
         if (vecs[i].e_wr != 0) begin
            chk($sformatf("vec%0d.wr_addr", i), wr_addr_seen, vecs[i].e_addr);
            chk($sformatf("vec%0d.wr_data", i), wr_data_seen, {24'h0, vecs[i].d});
         end
         chk($sformatf("vec%0d.data_in", i), {24'h0, i2c_data_in}, vecs[i].e_din);
         check_model($sformatf("vec%0d", i));
      end
      chk("plan.reg2", {24'h0, dut_reg(2)}, 8'hA5);
      chk("plan.reg3", {24'h0, dut_reg(3)}, 8'h5A);

      // ready/wr_en timing on a write byte, and data_in update on a read byte.
      do_start();
      send_byte(1'b0, 8'h05);
      measure_byte(1'b0, 8'hC3);
      analyse("tw", fl);
      do_start();
      send_byte(1'b0, 8'h02);
      do_start();
      measure_byte(1'b1, 8'h00);
      analyse("tr", fl);
      chk("tr.din_before", {24'h0, din_h[fl]}, 8'hA5);
      chk("tr.din_after", {24'h0, din_h[fl + 1]}, 8'h5A);
      do_stop();
      check_model("timing");

      // Byte event and stop coincide in WRITE; a later byte without start must not write.
      do_start();
      send_byte(1'b0, 8'h04);
      wr_seen = 0;
      i2c_r_w = 1'b0; i2c_data_out = 8'h6E;
      i2c_data_vld = 1'b1; tick(4);
      i2c_data_vld = 1'b0; i2c_stop = 1'b1; tick(8);
      i2c_stop = 1'b0; tick(4);
      m_byte(1'b0, 8'h6E);
      m_state = M_IDLE;
      check_model("bytestop");
      send_byte(1'b0, 8'h99);
      check_model("idle_byte");
      chk("idle_byte.no_write", wr_seen, 0);

      // Pointer at the last register followed by three writes.
      do_start();
      send_byte(1'b0, 8'h07);
      send_byte(1'b0, 8'h11);
      send_byte(1'b0, 8'h22);
      send_byte(1'b0, 8'h33);
      do_stop();
      check_model("edge");
`ifdef I2C_REGMAP_PTR_WRAP_EN
      chk("wrap.reg7", {24'h0, dut_reg(7)}, 8'h11);
      chk("wrap.reg0", {24'h0, dut_reg(0)}, 8'h22);
      chk("wrap.reg1", {24'h0, dut_reg(1)}, 8'h33);
`else
      chk("sat.reg7", {24'h0, dut_reg(7)}, 8'h33);
      chk("sat.reg0", {24'h0, dut_reg(0)}, 8'h00);
      chk("sat.reg1", {24'h0, dut_reg(1)}, 8'h00);
`endif

      // Reset between the first and second data byte.
      do_start();
      send_byte(1'b0, 8'h01);
      send_byte(1'b0, 8'h77);
      check_model("pre_rst");
      rst = 1'b1;
      tick(1);
      chk("mid_rst.ready", {31'h0, i2c_ready}, 0);
      chk("mid_rst.data_in", {24'h0, i2c_data_in}, 0);
      chk("mid_rst.wr_addr", {{(32-AW){1'b0}}, reg_wr_addr}, 0);
      chk("mid_rst.regs_lo", regs_flat[31:0], {4{RRST}});
      chk("mid_rst.regs_hi", regs_flat[63:32], {4{RRST}});
      rst = 1'b0;
      m_reset();
      tick(1);
      chk("mid_rst.ready_release", {31'h0, i2c_ready}, 1);
      tick(3);
      send_byte(1'b0, 8'h88);
      check_model("post_rst");

      // Randomized operation stream against the model.
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) do_start();
         else if (r == 2) do_stop();
         else send_byte(1'($urandom_range(0, 1)), 8'($urandom));
         check_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
